// File: rtl/playfield_array_if.sv
// Lock handshake between the falling-piece controller (master) and the
// playfield store (slave). A locked piece is four cells sharing one colour.
//   lock_valid  master -> slave  piece cells presented
//   lock_ready  slave -> master  store can accept a piece this cycle
//   lock_row    master -> slave  four 5-bit row indices, cell k at [5k+4:5k]
//   lock_col    master -> slave  four 4-bit column indices, cell k at [4k+3:4k]
//   lock_color  master -> slave  colour for all four cells
interface playfield_array_if #(
  parameter int COLOR_W = 3
);
  logic               lock_valid;
  logic               lock_ready;
  logic [19:0]        lock_row;
  logic [15:0]        lock_col;
  logic [COLOR_W-1:0] lock_color;

  modport master (
    output lock_valid, lock_row, lock_col, lock_color,
    input  lock_ready
  );

  modport slave (
    input  lock_valid, lock_row, lock_col, lock_color,
    output lock_ready
  );
endinterface

// File: rtl/playfield_array.sv
// Tetris playfield store: per-cell colour and occupancy for a COLS x ROWS
// grid (top HIDDEN_ROWS rows are spawn-only). Locks pieces, detects full
// visible rows, flashes them for FLASH_FRAMES frame ticks, compacts the field
// and updates score, line count and win/lose flags.
//   clk, reset_n  clock, asynchronous active-low reset
//   frame_tick    frame clock level (rising edge used)
//   clear_field   synchronous clear of field, counters and flags
//   lock          lock handshake (slave side)
//   rd_row/rd_col renderer read address; rd_color registered cell colour
//   occupancy     occupancy bit per cell, bit r*COLS+c
//   busy          FSM not idle
//   lines_total   cleared lines (saturating), score (saturating),
//   pieces        locked-piece count (wrapping), win/lose sticky flags
module playfield_array #(
  parameter int COLS         = 10,
  parameter int ROWS         = 24,
  parameter int HIDDEN_ROWS  = 4,
  parameter int COLOR_W      = 3,
  parameter int FLASH_FRAMES = 8,
  parameter int LINE_GOAL    = 36,
  parameter int SCORE_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_tick,
  input  logic                 clear_field,
  playfield_array_if.slave     lock,
  input  logic [4:0]           rd_row,
  input  logic [3:0]           rd_col,
  output logic [COLOR_W-1:0]   rd_color,
  output logic [ROWS*COLS-1:0] occupancy,
  output logic                 busy,
  output logic [7:0]           lines_total,
  output logic [SCORE_W-1:0]   score,
  output logic [15:0]          pieces,
  output logic                 win,
  output logic                 lose
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SCAN     = 3'd1;
  localparam logic [2:0] S_FLASH    = 3'd2;
  localparam logic [2:0] S_COLLAPSE = 3'd3;
  localparam logic [2:0] S_SCORE    = 3'd4;

  logic [2:0]                   state;
  logic [COLOR_W-1:0]           color_q [ROWS][COLS];
  logic [ROWS-1:0][COLS-1:0]    occ_q;
  logic [ROWS-1:0]              mask_q;
  logic [5:0]                   n_q;
  logic [7:0]                   flash_cnt;
  logic                         tick_q;

  logic                         tick_rise;
  logic                         accept;
  logic [ROWS-1:0][COLS-1:0]    lock_hit;
  logic [ROWS-1:0]              full_mask;
  logic [5:0]                   full_cnt;
  int unsigned                  sel_row;
  logic [ROWS-1:0]              mask_next;
  logic                         hidden_occ;
  logic [SCORE_W-1:0]           score_inc;
  logic [SCORE_W:0]             score_sum;
  logic [8:0]                   lines_sum;
  logic [7:0]                   lines_new;
  logic                         win_now;
  logic                         rd_in_range;

  assign lock.lock_ready = (state == S_IDLE) && !win && !lose;
  assign accept          = lock.lock_valid && lock.lock_ready;
  assign busy            = (state != S_IDLE);
  assign occupancy       = occ_q;
  assign tick_rise       = frame_tick && !tick_q;

  // Per-cell write strobe; out-of-range indices match no cell and are dropped.
  always_comb begin
    lock_hit = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          if (({27'd0, lock.lock_row[5*k +: 5]} == r) &&
              ({28'd0, lock.lock_col[4*k +: 4]} == c))
            lock_hit[r][c] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    full_mask = '0;
    full_cnt  = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      full_mask[r] = (r >= HIDDEN_ROWS) && (&occ_q[r]);
      full_cnt     = full_cnt + 6'(full_mask[r]);
    end
  end

  // Bottom-most flagged row; rows above it (lower indices) drop by one, and
  // their mask bits travel with them so later cycles find them again.
  always_comb begin
    sel_row = 0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (mask_q[r]) sel_row = r;
    end
    mask_next = '0;
    for (int unsigned r = 1; r < ROWS; r++) begin
      if (r <= sel_row) mask_next[r] = mask_q[r-1];
      else              mask_next[r] = mask_q[r];
    end
  end

  always_comb begin
    case (n_q)
      6'd0:    score_inc = SCORE_W'(0);
      6'd1:    score_inc = SCORE_W'(1);
      6'd2:    score_inc = SCORE_W'(3);
      6'd3:    score_inc = SCORE_W'(6);
      default: score_inc = SCORE_W'(10);
    endcase
    score_sum  = {1'b0, score} + {1'b0, score_inc};
    lines_sum  = {1'b0, lines_total} + {3'b0, n_q};
    lines_new  = lines_sum[8] ? 8'hFF : lines_sum[7:0];
    hidden_occ = |occ_q[HIDDEN_ROWS-1:0];
    win_now    = ({24'd0, lines_new} >= LINE_GOAL) && !hidden_occ;
  end

  assign rd_in_range = ({27'd0, rd_row} < ROWS) && ({28'd0, rd_col} < COLS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tick_q <= 1'b0;
    else          tick_q <= frame_tick;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++)
          color_q[r][c] <= '0;
      occ_q       <= '0;
      mask_q      <= '0;
      n_q         <= '0;
      flash_cnt   <= '0;
      state       <= S_IDLE;
      rd_color    <= '0;
      score       <= '0;
      lines_total <= '0;
      pieces      <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else if (clear_field) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++)
          color_q[r][c] <= '0;
      occ_q       <= '0;
      mask_q      <= '0;
      n_q         <= '0;
      flash_cnt   <= '0;
      state       <= S_IDLE;
      rd_color    <= '0;
      score       <= '0;
      lines_total <= '0;
      pieces      <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      rd_color <= rd_in_range ? color_q[rd_row][rd_col] : '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            for (int unsigned r = 0; r < ROWS; r++)
              for (int unsigned c = 0; c < COLS; c++)
                if (lock_hit[r][c]) begin
                  color_q[r][c] <= lock.lock_color;
                  occ_q[r][c]   <= 1'b1;
                end
            pieces <= pieces + 16'd1;
            state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (full_mask == '0) begin
            n_q   <= '0;
            state <= S_SCORE;
          end else begin
            mask_q    <= full_mask;
            n_q       <= full_cnt;
            flash_cnt <= '0;
            for (int unsigned r = 0; r < ROWS; r++)
              if (full_mask[r])
                for (int unsigned c = 0; c < COLS; c++)
                  color_q[r][c] <= '1;
            state <= S_FLASH;
          end
        end
        S_FLASH: begin
          if (tick_rise) begin
            if (flash_cnt == 8'(FLASH_FRAMES - 1)) state <= S_COLLAPSE;
            else                                    flash_cnt <= flash_cnt + 8'd1;
          end
        end
        S_COLLAPSE: begin
          for (int unsigned r = 0; r < ROWS; r++) begin
            if (r == 0) begin
              occ_q[r] <= '0;
              for (int unsigned c = 0; c < COLS; c++) color_q[r][c] <= '0;
            end else if (r <= sel_row) begin
              occ_q[r] <= occ_q[r-1];
              for (int unsigned c = 0; c < COLS; c++) color_q[r][c] <= color_q[r-1][c];
            end
          end
          mask_q <= mask_next;
          if (mask_next == '0) state <= S_SCORE;
        end
        S_SCORE: begin
          score       <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          lines_total <= lines_new;
          if (hidden_occ) lose <= 1'b1;
          if (win_now)    win  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_playfield_array.sv
module tb_playfield_array;
  localparam int COLS = 10;
  localparam int ROWS = 24;
  localparam int HID  = 4;
  localparam int CW   = 3;
  localparam int SW   = 16;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 frame_tick;
  logic                 clear_field;
  logic [4:0]           rd_row;
  logic [3:0]           rd_col;
  logic [CW-1:0]        rd_color;
  logic [ROWS*COLS-1:0] occupancy;
  logic                 busy;
  logic [7:0]           lines_total;
  logic [SW-1:0]        score;
  logic [15:0]          pieces;
  logic                 win;
  logic                 lose;

  playfield_array_if #(.COLOR_W(CW)) lock_if ();

  playfield_array #(
    .COLS(COLS), .ROWS(ROWS), .HIDDEN_ROWS(HID), .COLOR_W(CW),
    .FLASH_FRAMES(2), .LINE_GOAL(4), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .clear_field(clear_field),
    .lock(lock_if), .rd_row(rd_row), .rd_col(rd_col), .rd_color(rd_color),
    .occupancy(occupancy), .busy(busy), .lines_total(lines_total), .score(score),
    .pieces(pieces), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int m_col [ROWS][COLS];
  bit m_occ [ROWS][COLS];
  int m_pieces;
  int sb [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        m_col[r][c] = 0;
        m_occ[r][c] = 1'b0;
      end
    m_pieces = 0;
  endtask

  // Reference compaction: walk rows bottom-up and keep only the non-full ones.
  task automatic m_collapse();
    int nc [ROWS][COLS];
    bit no [ROWS][COLS];
    int dst;
    bit full;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        nc[r][c] = 0;
        no[r][c] = 1'b0;
      end
    dst = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = (r >= HID);
      for (int c = 0; c < COLS; c++) if (!m_occ[r][c]) full = 1'b0;
      if (!full) begin
        for (int c = 0; c < COLS; c++) begin
          nc[dst][c] = m_col[r][c];
          no[dst][c] = m_occ[r][c];
        end
        dst--;
      end
    end
    m_col = nc;
    m_occ = no;
  endtask

  task automatic lock_piece(input int r0, input int r1, input int r2, input int r3,
                            input int c0, input int c1, input int c2, input int c3,
                            input int color);
    int t;
    int rr [4];
    int cc [4];
    rr = '{r0, r1, r2, r3};
    cc = '{c0, c1, c2, c3};
    t = 0;
    while (!lock_if.lock_ready && t < 50) begin
      step();
      t++;
    end
    check("lock_ready_wait", 32'(lock_if.lock_ready), 32'd1);
    lock_if.lock_valid = 1'b1;
    lock_if.lock_row   = {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
    lock_if.lock_col   = {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
    lock_if.lock_color = CW'(color);
    step();
    lock_if.lock_valid = 1'b0;
    for (int k = 0; k < 4; k++)
      if (rr[k] < ROWS && cc[k] < COLS) begin
        m_col[rr[k]][cc[k]] = color;
        m_occ[rr[k]][cc[k]] = 1'b1;
      end
    m_pieces++;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int t;
    t = 0;
    while (busy && t < max_cycles) begin
      step();
      t++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic read_cell(input string tag, input int r, input int c, input int exp);
    rd_row = 5'(r);
    rd_col = 4'(c);
    sb.push_back(exp);
    step();
    check(tag, 32'(rd_color), 32'(sb.pop_front()));
  endtask

  task automatic check_field(input string tag);
    logic [ROWS*COLS-1:0] exp_occ;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        exp_occ[r*COLS + c] = m_occ[r][c];
        read_cell(tag, r, c, m_col[r][c]);
      end
    n_checks++;
    assert (occupancy === exp_occ) else begin
      n_fail++;
      $error("FAIL %s_occ: observed %0h expected %0h", tag, occupancy, exp_occ);
    end
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_ready"},  32'(lock_if.lock_ready), 32'd1);
    check({tag, "_score"},  32'(score), 32'd0);
    check({tag, "_lines"},  32'(lines_total), 32'd0);
    check({tag, "_pieces"}, 32'(pieces), 32'd0);
    check({tag, "_win"},    32'(win), 32'd0);
    check({tag, "_lose"},   32'(lose), 32'd0);
    check({tag, "_occ"},    32'(occupancy != '0), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset_n = 1'b0;
    frame_tick = 1'b0;
    clear_field = 1'b0;
    rd_row = '0;
    rd_col = '0;
    lock_if.lock_valid = 1'b0;
    lock_if.lock_row = '0;
    lock_if.lock_col = '0;
    lock_if.lock_color = '0;
    m_reset();
    step();
    step();
    reset_n = 1'b1;
    step();

    // Reset state
    check_empty("reset");
    check("reset_rd_color", 32'(rd_color), 32'd0);

    // Vertical I at col 0, rows 20..23: latency and contents
    lock_piece(20, 21, 22, 23, 0, 0, 0, 0, 3);
    check("t1_pieces", 32'(pieces), 32'd1);
    check("t1_busy_scan", 32'(busy), 32'd1);
    check("t1_ready_scan", 32'(lock_if.lock_ready), 32'd0);
    step();
    check("t1_busy_score", 32'(busy), 32'd1);
    step();
    check("t1_busy_idle", 32'(busy), 32'd0);
    check("t1_ready_idle", 32'(lock_if.lock_ready), 32'd1);
    check("t1_score", 32'(score), 32'd0);
    read_cell("t1_rd_23_0", 23, 0, 3);
    check_field("t1_field");

    // Single line: complete row 23 over three pieces
    lock_piece(23, 23, 23, 23, 1, 2, 3, 4, 1);
    lock_piece(23, 23, 23, 23, 5, 6, 7, 8, 2);
    lock_piece(20, 21, 22, 23, 9, 9, 9, 9, 4);
    step();
    check("t2_busy_flash", 32'(busy), 32'd1);
    for (int c = 0; c < COLS; c++) read_cell("t2_flash_row", 23, c, 7);
    tick();
    read_cell("t2_flash_after_1tick", 23, 0, 7);
    check("t2_busy_after_1tick", 32'(busy), 32'd1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin
      step();
      cnt++;
    end
    check("t2_collapse_latency", 32'(cnt), 32'd2);
    m_collapse();
    check("t2_score", 32'(score), 32'd1);
    check("t2_lines", 32'(lines_total), 32'd1);
    check("t2_pieces", 32'(pieces), 32'(m_pieces));
    check_field("t2_field");

    // Clear_Field, then a non-adjacent double (rows 20 and 22)
    clear_field = 1'b1;
    step();
    clear_field = 1'b0;
    m_reset();
    check_empty("clear1");
    lock_piece(20, 20, 20, 20, 0, 1, 2, 3, 1);
    lock_piece(20, 20, 20, 20, 4, 5, 6, 7, 2);
    lock_piece(22, 22, 22, 22, 0, 1, 2, 3, 5);
    lock_piece(22, 22, 22, 22, 4, 5, 6, 7, 6);
    lock_piece(20, 22, 21, 19, 8, 8, 5, 3, 1);
    wait_idle("t3_prefill_idle", 10);
    check("t3_no_clear_yet", 32'(lines_total), 32'd0);
    lock_piece(20, 21, 22, 23, 9, 9, 9, 9, 4);
    step();
    tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin
      step();
      cnt++;
    end
    check("t3_collapse_latency", 32'(cnt), 32'd3);
    m_collapse();
    check("t3_score", 32'(score), 32'd3);
    check("t3_lines", 32'(lines_total), 32'd2);
    check_field("t3_field");

    // Tetris with LINE_GOAL=4 -> Win
    for (int c = 1; c < COLS; c++) lock_piece(20, 21, 22, 23, c, c, c, c, (c % 6) + 1);
    lock_piece(20, 21, 22, 23, 0, 0, 0, 0, 3);
    step();
    tick();
    tick();
    wait_idle("t4_idle", 20);
    m_collapse();
    check("t4_score", 32'(score), 32'd13);
    check("t4_lines", 32'(lines_total), 32'd6);
    check("t4_win", 32'(win), 32'd1);
    check("t4_lose", 32'(lose), 32'd0);
    check("t4_ready", 32'(lock_if.lock_ready), 32'd0);
    check_field("t4_field");
    lock_if.lock_valid = 1'b1;
    lock_if.lock_row = {5'd23, 5'd23, 5'd23, 5'd23};
    lock_if.lock_col = {4'd3, 4'd2, 4'd1, 4'd0};
    step();
    step();
    lock_if.lock_valid = 1'b0;
    check("t4_no_accept_pieces", 32'(pieces), 32'(m_pieces));
    check("t4_no_accept_busy", 32'(busy), 32'd0);
    clear_field = 1'b1;
    step();
    clear_field = 1'b0;
    m_reset();
    check_empty("clear2");

    // Top-out: piece reaching hidden row 3
    lock_piece(3, 4, 5, 6, 2, 2, 2, 2, 2);
    step();
    step();
    check("t5_lose", 32'(lose), 32'd1);
    check("t5_win", 32'(win), 32'd0);
    check("t5_ready", 32'(lock_if.lock_ready), 32'd0);
    lock_if.lock_valid = 1'b1;
    step();
    step();
    lock_if.lock_valid = 1'b0;
    check("t5_no_accept_pieces", 32'(pieces), 32'd1);
    clear_field = 1'b1;
    step();
    clear_field = 1'b0;
    m_reset();
    check_empty("clear3");
    check("clear3_rd_color", 32'(rd_color), 32'd0);

    // Clear_Field together with a valid handshake discards the lock
    lock_if.lock_valid = 1'b1;
    lock_if.lock_row = {5'd23, 5'd23, 5'd23, 5'd23};
    lock_if.lock_col = {4'd3, 4'd2, 4'd1, 4'd0};
    lock_if.lock_color = 3'd2;
    clear_field = 1'b1;
    step();
    clear_field = 1'b0;
    lock_if.lock_valid = 1'b0;
    check_empty("clear_vs_lock");

    // Async reset mid-FLASH
    lock_piece(23, 23, 23, 23, 0, 1, 2, 3, 1);
    lock_piece(23, 23, 23, 23, 4, 5, 6, 7, 2);
    lock_piece(23, 23, 22, 21, 8, 9, 0, 0, 6);
    step();
    tick();
    check("t6_busy_flash", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #2;
    check_empty("async_reset");
    check("async_reset_rd", 32'(rd_color), 32'd0);
    reset_n = 1'b1;
    m_reset();
    step();

    // Clear_Field mid-COLLAPSE
    lock_piece(23, 23, 23, 23, 0, 1, 2, 3, 1);
    lock_piece(23, 23, 23, 23, 4, 5, 6, 7, 2);
    lock_piece(23, 23, 22, 21, 8, 9, 0, 0, 6);
    step();
    tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("t6_busy_collapse", 32'(busy), 32'd1);
    clear_field = 1'b1;
    step();
    clear_field = 1'b0;
    m_reset();
    check_empty("clear_collapse");

    // Out-of-range cell is dropped, the rest written
    lock_piece(23, 23, 23, 22, 0, 1, 12, 0, 5);
    wait_idle("t6_drop_idle", 10);
    check("t6_drop_pieces", 32'(pieces), 32'd1);
    check_field("t6_drop_field");
    read_cell("rd_row_oob", 25, 0, 0);
    read_cell("rd_col_oob", 23, 11, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
